// File: rtl/minimig_autoconfig_chain.sv
// Amiga autoconfig daisy chain: presents one board descriptor at a time in the
// $E8xxxx space and assigns Z2/Z3 base addresses or shuts boards up in slot order.
module minimig_autoconfig_chain #(
  parameter int unsigned NUM_BOARDS = 4,
  parameter int unsigned IDXW       = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BOARDS-1:0]      board_en,
  input  logic [NUM_BOARDS-1:0]      board_z3,
  input  logic                       rom_we,
  input  logic [IDXW+5:0]            rom_a,
  input  logic [3:0]                 rom_d,
  input  logic                       cfg_sel,
  input  logic                       cfg_rd,
  input  logic                       cfg_wr,
  input  logic [5:0]                 cfg_a,
  input  logic [15:0]                cfg_wdata,
  output logic [15:0]                cfg_rdata,
  output logic [16*NUM_BOARDS-1:0]   base_addr,
  output logic [NUM_BOARDS-1:0]      board_cfg,
  output logic [NUM_BOARDS-1:0]      board_shut,
  output logic                       cfg_done
);

  localparam int unsigned DEPTH = NUM_BOARDS * 64;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDXW-1:0]           cur_q, cur_d;
  logic [NUM_BOARDS-1:0]     visited_q, visited_d;
  logic [3:0]                latch_q, latch_d;
  logic [16*NUM_BOARDS-1:0]  base_d;
  logic [NUM_BOARDS-1:0]     cfg_d, shut_d;
  logic [15:0]               rdata_d;
  logic                      done_d;

  logic                      rd, wr, found;
  logic [IDXW-1:0]           pick;
  logic [3:0]                ram_nib, nib;

  // Descriptor store holds true nibbles; erased locations read as 4'hF
  logic [3:0] mem [DEPTH] = '{default: 4'hF};

  // Write port stays live through reset so software can preload descriptors
  always_ff @(posedge clk) begin
    if (rom_we) mem[rom_a] <= rom_d;
  end

  assign rd = cfg_sel && cfg_rd;
  assign wr = cfg_sel && cfg_wr;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    visited_d = visited_q;
    latch_d   = latch_q;
    base_d    = base_addr;
    cfg_d     = board_cfg;
    shut_d    = board_shut;
    rdata_d   = cfg_rdata;
    found     = 1'b0;
    pick      = '0;

    // Lowest enabled slot not yet handled
    for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
      if (board_en[i] && !visited_q[i]) begin
        found = 1'b1;
        pick  = IDXW'(i);
      end
    end

    // Only offsets $00/$02 are stored true; everything else reads inverted
    ram_nib = mem[{cur_q, cfg_a}];
    nib     = (cfg_a == 6'h00 || cfg_a == 6'h01) ? ram_nib : ~ram_nib;

    if (rd) rdata_d = (state_q == ACTIVE) ? {nib, 12'hFFF} : 16'hFFFF;

    unique case (state_q)
      SCAN: begin
        latch_d = 4'h0;
        if (found) begin
          cur_d   = pick;
          state_d = ACTIVE;
        end else begin
          state_d = DONE;
        end
      end
      ACTIVE: begin
        if (wr) begin
          if (cfg_a == 6'h25 && !board_z3[cur_q]) begin
            latch_d = cfg_wdata[15:12];
          end else if (cfg_a == 6'h24 && !board_z3[cur_q]) begin
            base_d[{cur_q, 4'b0000} +: 16] = {8'h00, cfg_wdata[15:12], latch_q};
            cfg_d[cur_q]     = 1'b1;
            visited_d[cur_q] = 1'b1;
            state_d          = SCAN;
          end else if (cfg_a == 6'h22 && board_z3[cur_q]) begin
            base_d[{cur_q, 4'b0000} +: 16] = cfg_wdata;
            cfg_d[cur_q]     = 1'b1;
            visited_d[cur_q] = 1'b1;
            state_d          = SCAN;
          end else if (cfg_a == 6'h26) begin
            shut_d[cur_q]    = 1'b1;
            visited_d[cur_q] = 1'b1;
            state_d          = SCAN;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = SCAN;
      end
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      cur_q      <= '0;
      visited_q  <= '0;
      latch_q    <= 4'h0;
      base_addr  <= '0;
      board_cfg  <= '0;
      board_shut <= '0;
      cfg_rdata  <= 16'hFFFF;
      cfg_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      visited_q  <= visited_d;
      latch_q    <= latch_d;
      base_addr  <= base_d;
      board_cfg  <= cfg_d;
      board_shut <= shut_d;
      cfg_rdata  <= rdata_d;
      cfg_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_minimig_autoconfig_chain.sv
// Directed bench for the autoconfig chain; read data checked through a scoreboard queue.
module tb_minimig_autoconfig_chain;

  localparam int unsigned NB = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NB-1:0]   board_en, board_z3;
  logic            rom_we;
  logic [IW+5:0]   rom_a;
  logic [3:0]      rom_d;
  logic            cfg_sel, cfg_rd, cfg_wr;
  logic [5:0]      cfg_a;
  logic [15:0]     cfg_wdata;
  logic [15:0]     cfg_rdata;
  logic [16*NB-1:0] base_addr;
  logic [NB-1:0]   board_cfg, board_shut;
  logic            cfg_done;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  minimig_autoconfig_chain #(.NUM_BOARDS(NB), .IDXW(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .board_en   (board_en),
    .board_z3   (board_z3),
    .rom_we     (rom_we),
    .rom_a      (rom_a),
    .rom_d      (rom_d),
    .cfg_sel    (cfg_sel),
    .cfg_rd     (cfg_rd),
    .cfg_wr     (cfg_wr),
    .cfg_a      (cfg_a),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .base_addr  (base_addr),
    .board_cfg  (board_cfg),
    .board_shut (board_shut),
    .cfg_done   (cfg_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [15:0] exp);
    cfg_sel = 1'b1; cfg_rd = 1'b1; cfg_a = a;
    exp_q.push_back(exp);
    @(negedge clk);
    cfg_sel = 1'b0; cfg_rd = 1'b0;
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    else chk(tag, 64'(cfg_rdata), 64'(exp_q.pop_front()));
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic sel = 1'b1);
    cfg_sel = sel; cfg_wr = 1'b1; cfg_a = a; cfg_wdata = d;
    @(negedge clk);
    cfg_sel = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic romw(input logic [IW-1:0] s, input logic [5:0] i, input logic [3:0] d);
    rom_we = 1'b1; rom_a = {s, i}; rom_d = d;
    @(negedge clk);
    rom_we = 1'b0;
  endtask

  task automatic do_reset(input logic [NB-1:0] en, input logic [NB-1:0] z3);
    reset = 1'b1; board_en = en; board_z3 = z3;
    tick(2);
    chk("rst_rdata", 64'(cfg_rdata), 64'hFFFF);
    chk("rst_base", 64'(base_addr), 64'h0);
    chk("rst_cfg", 64'(board_cfg), 64'h0);
    chk("rst_shut", 64'(board_shut), 64'h0);
    chk("rst_done", 64'(cfg_done), 64'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; board_en = '1; board_z3 = '0;
    rom_we = 1'b0; rom_a = '0; rom_d = '0;
    cfg_sel = 1'b0; cfg_rd = 1'b0; cfg_wr = 1'b0; cfg_a = '0; cfg_wdata = '0;
    @(negedge clk);

    // Descriptors loaded while the chain is held in reset
    romw(2'd0, 6'h00, 4'hE);
    romw(2'd0, 6'h08, 4'hE);
    romw(2'd1, 6'h00, 4'h3);
    romw(2'd2, 6'h00, 4'h6);
    romw(2'd3, 6'h00, 4'h9);

    // All four slots enabled, Z2
    do_reset(4'b1111, 4'b0000);
    rd("scan_read", 6'h00, 16'hFFFF);
    rd("s0_off00", 6'h00, 16'hEFFF);
    rd("s0_off10", 6'h08, 16'h1FFF);
    rd("s0_off02_erased", 6'h01, 16'hFFFF);
    rd("s0_off04_inv_erased", 6'h02, 16'h0FFF);
    tick(2);
    chk("rdata_hold", 64'(cfg_rdata), 64'h0FFF);

    // Same-cycle descriptor write and read: old value first, new value next
    rom_we = 1'b1; rom_a = 8'h00; rom_d = 4'h5;
    rd("rw_old", 6'h00, 16'hEFFF);
    rom_we = 1'b0;
    rd("rw_new", 6'h00, 16'h5FFF);

    wr(6'h25, 16'h7000);
    chk("latch_no_cfg", 64'(board_cfg), 64'h0);
    rd("latch_still_s0", 6'h00, 16'h5FFF);
    wr(6'h24, 16'h2000);
    chk("s0_base", 64'(base_addr[15:0]), 64'h0027);
    chk("s0_cfg", 64'(board_cfg), 64'b0001);
    rd("scan_after_s0", 6'h00, 16'hFFFF);
    rd("s1_off00", 6'h00, 16'h3FFF);

    // Ignored writes: Z3 register on Z2 slot, unknown offset, unselected strobe
    wr(6'h22, 16'h1234);
    wr(6'h20, 16'hFFFF);
    wr(6'h24, 16'h5000, 1'b0);
    chk("ignored_cfg", 64'(board_cfg), 64'b0001);
    chk("ignored_base", 64'(base_addr[31:16]), 64'h0);
    rd("s1_still", 6'h00, 16'h3FFF);

    // No $4A write for slot 1: low nibble must be zero
    wr(6'h24, 16'hA000);
    chk("s1_base_nolatch", 64'(base_addr[31:16]), 64'h00A0);
    chk("s1_cfg", 64'(board_cfg), 64'b0011);
    rd("scan_after_s1", 6'h00, 16'hFFFF);
    rd("s2_off00", 6'h00, 16'h6FFF);
    wr(6'h26, 16'h0000);
    chk("s2_shut", 64'(board_shut), 64'b0100);
    chk("s2_base_untouched", 64'(base_addr[47:32]), 64'h0);
    tick(1);
    rd("s3_off00", 6'h00, 16'h9FFF);
    wr(6'h26, 16'h0000);
    chk("s3_shut", 64'(board_shut), 64'b1100);
    chk("done_not_yet", 64'(cfg_done), 64'h0);
    tick(1);
    chk("done_set", 64'(cfg_done), 64'h1);
    rd("done_read", 6'h00, 16'hFFFF);
    wr(6'h24, 16'h3000);
    chk("done_base", 64'(base_addr), {32'h0, 16'h00A0, 16'h0027});
    chk("done_cfg", 64'(board_cfg), 64'b0011);
    chk("done_hold", 64'(cfg_done), 64'h1);

    // Reset after slot 0 configured discards progress, keeps descriptors
    do_reset(4'b1111, 4'b0000);
    tick(1);
    wr(6'h25, 16'h1000);
    wr(6'h24, 16'h3000);
    chk("s0_base_again", 64'(base_addr[15:0]), 64'h0031);
    do_reset(4'b1111, 4'b0000);
    rd("scan_after_rst", 6'h00, 16'hFFFF);
    rd("s0_visible_again", 6'h00, 16'h5FFF);
    rd("ram_kept", 6'h08, 16'h1FFF);

    // Sparse chain with a Z3 board in slot 1
    do_reset(4'b1010, 4'b0010);
    rd("sparse_scan", 6'h00, 16'hFFFF);
    rd("sparse_first_s1", 6'h00, 16'h3FFF);
    wr(6'h24, 16'h1234);
    wr(6'h25, 16'h1234);
    chk("z3_ignores_z2regs", 64'(board_cfg), 64'h0);
    rd("z3_still_s1", 6'h00, 16'h3FFF);
    wr(6'h22, 16'h4000);
    chk("z3_base", 64'(base_addr), {32'h0, 16'h4000, 16'h0});
    chk("z3_cfg", 64'(board_cfg), 64'b0010);
    rd("sparse_scan2", 6'h00, 16'hFFFF);
    rd("sparse_s3", 6'h00, 16'h9FFF);
    wr(6'h26, 16'h0000);
    tick(1);
    chk("sparse_done", 64'(cfg_done), 64'h1);
    chk("sparse_shut", 64'(board_shut), 64'b1000);

    // Shut up every enabled board; a write during SCAN is ignored
    do_reset(4'b1010, 4'b0000);
    wr(6'h26, 16'h0000);
    chk("scan_write_ignored", 64'(board_shut), 64'h0);
    wr(6'h26, 16'h0000);
    tick(1);
    wr(6'h26, 16'h0000);
    tick(1);
    chk("all_shut", 64'(board_shut), 64'b1010);
    chk("all_shut_cfg", 64'(board_cfg), 64'h0);
    chk("all_shut_done", 64'(cfg_done), 64'h1);
    rd("all_shut_rd00", 6'h00, 16'hFFFF);
    rd("all_shut_rd10", 6'h08, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/minimig_autoconfig_chain.md
MINIMIG_AUTOCONFIG_CHAIN -- requirements
Module: minimig_autoconfig_chain

Interface
REQ-001 SHALL have parameter NUM_BOARDS, default 4, meaning number of chain slots (1..8).
REQ-002 SHALL have parameter IDXW, default 2, meaning slot index width, equal to clog2(NUM_BOARDS), minimum 1.
REQ-003 SHALL have port clk  input  1  system clock; only clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port board_en  input  NUM_BOARDS  per-slot enable; static while reset is low.
REQ-006 SHALL have port board_z3  input  NUM_BOARDS  per-slot type, 1 = Zorro III, 0 = Zorro II.
REQ-007 SHALL have port rom_we / rom_a / rom_d  input  1 / IDXW+6 / 4  descriptor write port; slot = rom_a[IDXW+5:6], nibble = rom_a[5:0].
REQ-008 SHALL have port cfg_sel  input  1  CPU cycle targets the $E8xxxx autoconfig space.
REQ-009 SHALL have port cfg_rd / cfg_wr  input  1 / 1  single-cycle read and write strobes, qualified by cfg_sel.
REQ-010 SHALL have port cfg_a  input  6  word address bits A6..A1.
REQ-011 SHALL have port cfg_wdata  input  16  CPU write data.
REQ-012 SHALL have port cfg_rdata  output  16  read data.
REQ-013 SHALL have port base_addr  output  16*NUM_BOARDS  per-slot base; Z2 = {8'h00, A23..A16}, Z3 = A31..A16.
REQ-014 SHALL have port board_cfg / board_shut  output  NUM_BOARDS each  slot configured / slot shut up.
REQ-015 SHALL have port cfg_done  output  1  chain exhausted.

Function
REQ-016 SHALL store descriptors in a NUM_BOARDS*64 x 4 synchronous RAM that holds true (non-inverted) nibble values and initialises every location to 4'hF.
REQ-017 SHALL write rom_d to rom_a on each clk edge with rom_we high; the descriptor write port is active during reset.
REQ-018 SHALL, on a read of the same address in the same cycle as a write, return the old RAM data.
REQ-019 SHALL, for each cfg_sel&&cfg_rd, present cfg_rdata exactly 1 cycle later and hold it until the next read.
REQ-020 SHALL format cfg_rdata as {nibble, 12'hFFF}, where nibble = RAM[{cur, cfg_a}] for cfg_a 0/1 (offsets $00/$02) and the bitwise inverse for all other cfg_a values.
REQ-021 SHALL return cfg_rdata = 16'hFFFF when cfg_done is 1 (null board).
REQ-022 SHALL use states SCAN, ACTIVE and DONE, with register cur[IDXW-1:0] holding the currently visible slot.
REQ-023 SCAN: cur = lowest enabled index not yet visited; enter ACTIVE the next cycle; if no enabled slot remains, enter DONE. SCAN lasts 1 cycle, and reads during SCAN return 16'hFFFF.
REQ-024 SHALL, for a Z2 slot (board_z3[cur]=0) on a write to $4A (cfg_a=6'h25), latch cfg_wdata[15:12] as the low nibble, A19..A16, with no state change.
REQ-025 SHALL, for a Z2 slot on a write to $48 (cfg_a=6'h24), set base_addr[cur] = {8'h00, cfg_wdata[15:12], latch}, set board_cfg[cur], and go to SCAN.
REQ-026 SHALL, for a Z2 slot with no prior $4A write since the slot became ACTIVE, use latch = 4'h0.
REQ-027 SHALL, for a Z3 slot on a write to $44 (cfg_a=6'h22), set base_addr[cur] = cfg_wdata, set board_cfg[cur], and go to SCAN; writes to $48/$4A are ignored for Z3 slots.
REQ-028 SHALL, on a write to $4C (cfg_a=6'h26) in ACTIVE, set board_shut[cur], leave base_addr unchanged, and go to SCAN.
REQ-029 SHALL ignore every other write address, and any write in SCAN or DONE.
REQ-030 SHALL ignore cfg_rd and cfg_wr unless cfg_sel is high.
REQ-031 SHALL hold DONE until reset, with cfg_done = 1.
REQ-032 SHALL skip disabled slots entirely; their board_cfg, board_shut and base_addr stay at reset values.
REQ-033 SHALL have cur advance strictly upward and never wrap; after slot NUM_BOARDS-1 is handled, the block enters DONE.
REQ-034 SHALL make base_addr, board_cfg and board_shut change on the clock edge that accepts the write.

Reset
REQ-035 SHALL, on reset, clear base_addr to 0, board_cfg and board_shut to 0, latch to 0, cfg_done to 0, cfg_rdata to 16'hFFFF, and set state to SCAN with the visited set cleared.
REQ-036 SHALL, on reset mid-configuration, discard all progress; the chain restarts at the lowest enabled slot in the first cycle after reset is deasserted.
REQ-037 SHALL leave descriptor RAM contents unaffected by reset.

Verification
REQ-038 Program slot 0 offset 0 = 4'hE and offset $10 nibble = 4'hE, all slots enabled, Z2; read $00 -> 16'hEFFF after 1 cycle; read $10 -> 16'h1FFF.
REQ-039 Z2 slot 0: write $4A data 16'h0000, then $48 data 16'h2000 -> base_addr[0]=16'h0020, board_cfg[0]=1, slot 1 visible after the 1 SCAN cycle.
REQ-040 board_en=4'b1010, board_z3=4'b0010: first visible slot is 1; write $44 data 16'h4000 -> base_addr[1]=16'h4000; then slot 3 visible.
REQ-041 Write $4C to every enabled slot -> board_shut = board_en, board_cfg=0, cfg_done=1, all reads 16'hFFFF.
REQ-042 Assert reset after slot 0 is configured -> all outputs at reset values; slot 0 is visible again and RAM contents are unchanged.
REQ-043 rom_we to {cur, 6'h00} in the same cycle as a read of $00 -> old nibble returned; new nibble returned on the next read.
